avalon_aes_regfile: RTL and testbench
=====================================

AVALON_AES_REGFILE -- requirements
Module: avalon_aes_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, Avalon data width in bits (multiple of 8).
REQ-002 SHALL have parameter KEY_WORDS, default 4, number of key words.
REQ-003 SHALL have parameter MSG_WORDS, default 4, number of words per message.
REQ-004 SHALL have parameter ADDR_W, default 4, word-address width.
REQ-005 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-007 SHALL have ports AVL_READ, AVL_WRITE, AVL_CS  input  1 each  Avalon-MM read strobe, write strobe and chip select.
REQ-008 SHALL have port AVL_BYTE_EN  input  DATA_W/8  per-byte write enable.
REQ-009 SHALL have port AVL_ADDR  input  ADDR_W  word address.
REQ-010 SHALL have port AVL_WRITEDATA  input  DATA_W  write data.
REQ-011 SHALL have port AVL_READDATA  output  DATA_W  registered read data.
REQ-012 SHALL have port AES_START  output  1  level request to the decryption core.
REQ-013 SHALL have port AES_DONE  input  1  core completion, may be a one-cycle pulse.
REQ-014 SHALL have port AES_MSG_DEC  input  MSG_WORDS*DATA_W  core result, word 0 in the MSBs.
REQ-015 SHALL have port AES_KEY  output  KEY_WORDS*DATA_W  key registers, word 0 in the MSBs.
REQ-016 SHALL have port AES_MSG_ENC  output  MSG_WORDS*DATA_W  encrypted message registers, word 0 in the MSBs.
REQ-017 SHALL have port EXPORT_DATA  output  DATA_W  {key word 0 upper half, key word KEY_WORDS-1 lower half}.

Function
REQ-018 Map: key at 0..K-1, encrypted message at K..K+M-1, decrypted message at K+M..K+2M-1, CYCLES at 2^ADDR_W-3, START at 2^ADDR_W-2, DONE at 2^ADDR_W-1.
REQ-019 An elaboration-time check SHALL fail when K+2M > 2^ADDR_W-3.
REQ-020 A write SHALL occur only when AVL_CS and AVL_WRITE are both 1, updating only the bytes whose AVL_BYTE_EN bit is set.
REQ-021 Decrypted, CYCLES and DONE registers SHALL be read-only, and writes to them SHALL be ignored.
REQ-022 Writes to unmapped addresses SHALL be ignored, and reads of unmapped addresses SHALL return 0.
REQ-023 Read latency SHALL be 1: AVL_READDATA in cycle N+1 reflects the register contents before any write in cycle N (read-before-write).
REQ-024 When no read is active, AVL_READDATA SHALL hold its previous value.
REQ-025 FSM states SHALL be IDLE, RUN and DONE; AES_START SHALL be 1 only in RUN.
REQ-026 In IDLE, a write of START bit0=1 SHALL go to RUN and clear CYCLES to 0.
REQ-027 In RUN, AES_DONE=1 SHALL capture AES_MSG_DEC into the decrypted registers, set DONE bit0=1 and go to DONE.
REQ-028 In RUN, CYCLES SHALL increment each cycle and saturate at all-ones.
REQ-029 In RUN, writes to key and encrypted registers SHALL be ignored.
REQ-030 In RUN or DONE, a write of START bit0=0 SHALL go to IDLE and clear DONE, while the decrypted registers keep their values.
REQ-031 If START is written to 0 in the same cycle that AES_DONE=1 in RUN, the abort SHALL win: go to IDLE with no capture and DONE=0.
REQ-032 START readback SHALL be {0, state!=IDLE}, and DONE readback SHALL be {0, state==DONE}.
REQ-033 AES_DONE SHALL be ignored outside RUN, and a START=1 write outside IDLE SHALL be ignored.

Reset
REQ-034 RESET=1 at a clock edge SHALL clear all registers, CYCLES, DONE and AVL_READDATA to 0, force IDLE and drive AES_START=0, including in the middle of RUN.
REQ-035 RESET SHALL take priority over any simultaneous Avalon write or AES_DONE.

Structure
REQ-036 The FSM state typedef and address-offset functions of (K, M, ADDR_W) SHALL reside in shared package aes_regfile_pkg.
REQ-037 The byte-enable merge SHALL be one sub-module, be_merge (old, new, byte enables -> merged word), instanced per writable register.

Verification
REQ-038 Reset, then write 0xDEADBEEF with BE=4'b0011 to address 0 -> a read of address 0 returns 0x0000BEEF one cycle later.
REQ-039 Write the key 0x00112233..0xCCDDEEFF and START=1 -> AES_START=1 next cycle; AES_DONE pulse after 10 cycles with AES_MSG_DEC=0xA5..A5 -> DONE reads 1, addresses 8-11 read 0xA5A5A5A5, CYCLES reads 10.
REQ-040 During RUN, write 0xFFFFFFFF to address 0 -> address 0 unchanged and AES_KEY unchanged.
REQ-041 In RUN, write START=0 in the same cycle as AES_DONE=1 -> state IDLE, DONE reads 0, decrypted registers unchanged.
REQ-042 Assert RESET mid-RUN -> next cycle AES_START=0 and all reads return 0.
REQ-043 Read and write address 14 in the same cycle, and read address 12 -> old START value returned, and address 12 returns 0.

Source files
------------

// File: rtl/aes_regfile_pkg.sv
// rtl/aes_regfile_pkg.sv - shared FSM state type and register map offsets for the AES register file
package aes_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Key words sit at the bottom of the map.
  function automatic int key_base();
    return 0;
  endfunction

  function automatic int enc_base(input int k);
    return k;
  endfunction

  function automatic int dec_base(input int k, input int m);
    return k + m;
  endfunction

  // First address past the message/key block.
  function automatic int map_end(input int k, input int m);
    return k + 2 * m;
  endfunction

  // The three control registers occupy the top of the address space.
  function automatic int cycles_addr(input int addr_w);
    return (1 << addr_w) - 3;
  endfunction

  function automatic int start_addr(input int addr_w);
    return (1 << addr_w) - 2;
  endfunction

  function automatic int done_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/avalon_aes_regfile_be_merge.sv
// rtl/avalon_aes_regfile_be_merge.sv - byte-enable merge of a new word into an old word
module be_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   new_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   merged_o
);

  // Each enabled byte lane takes the new data, the others keep the old data.
  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (be_i[b]) merged_o[b*8 +: 8] = new_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/avalon_aes_regfile.sv
// rtl/avalon_aes_regfile.sv - Avalon-MM register file and start/done handshake for an AES decryption core
module avalon_aes_regfile
  import aes_regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int KEY_WORDS = 4,
  parameter int MSG_WORDS = 4,
  parameter int ADDR_W    = 4
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           AVL_READ,
  input  logic                           AVL_WRITE,
  input  logic                           AVL_CS,
  input  logic [DATA_W/8-1:0]            AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]              AVL_ADDR,
  input  logic [DATA_W-1:0]              AVL_WRITEDATA,
  output logic [DATA_W-1:0]              AVL_READDATA,
  output logic                           AES_START,
  input  logic                           AES_DONE,
  input  logic [MSG_WORDS*DATA_W-1:0]    AES_MSG_DEC,
  output logic [KEY_WORDS*DATA_W-1:0]    AES_KEY,
  output logic [MSG_WORDS*DATA_W-1:0]    AES_MSG_ENC,
  output logic [DATA_W-1:0]              EXPORT_DATA
);

  localparam int KEY_BASE  = key_base();
  localparam int ENC_BASE  = enc_base(KEY_WORDS);
  localparam int DEC_BASE  = dec_base(KEY_WORDS, MSG_WORDS);
  localparam int CYC_ADDR  = cycles_addr(ADDR_W);
  localparam int STA_ADDR  = start_addr(ADDR_W);
  localparam int DONE_ADDR = done_addr(ADDR_W);

  if (map_end(KEY_WORDS, MSG_WORDS) > CYC_ADDR) begin : g_map_check
    $error("avalon_aes_regfile: key and message registers overlap the control registers");
  end

  logic                wr_en;
  logic                rd_en;
  logic                start_wr;
  logic                start_bit;
  logic [DATA_W-1:0]   key_q        [KEY_WORDS];
  logic [DATA_W-1:0]   key_merged   [KEY_WORDS];
  logic [DATA_W-1:0]   enc_q        [MSG_WORDS];
  logic [DATA_W-1:0]   enc_merged   [MSG_WORDS];
  logic [DATA_W-1:0]   dec_q        [MSG_WORDS];
  logic [DATA_W-1:0]   cycles_q;
  logic [DATA_W-1:0]   readdata_q;
  logic [DATA_W-1:0]   readdata_d;
  logic                start_q;
  aes_state_e          state_q;

  assign wr_en    = AVL_CS & AVL_WRITE;
  assign rd_en    = AVL_CS & AVL_READ;
  assign start_wr = wr_en && (AVL_ADDR == ADDR_W'(STA_ADDR));
  // A write with byte lane 0 disabled leaves the start bit at its current readback value.
  assign start_bit = AVL_BYTE_EN[0] ? AVL_WRITEDATA[0] : (state_q != ST_IDLE);

  for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key
    be_merge #(.DATA_W(DATA_W)) u_be_merge (
      .old_i    (key_q[i]),
      .new_i    (AVL_WRITEDATA),
      .be_i     (AVL_BYTE_EN),
      .merged_o (key_merged[i])
    );

    // Key word is writable except while the core is running.
    always_ff @(posedge CLK) begin
      if (RESET) key_q[i] <= '0;
      else if (wr_en && state_q != ST_RUN && AVL_ADDR == ADDR_W'(KEY_BASE + i))
        key_q[i] <= key_merged[i];
    end

    assign AES_KEY[(KEY_WORDS-i)*DATA_W-1 -: DATA_W] = key_q[i];
  end

  for (genvar i = 0; i < MSG_WORDS; i++) begin : g_enc
    be_merge #(.DATA_W(DATA_W)) u_be_merge (
      .old_i    (enc_q[i]),
      .new_i    (AVL_WRITEDATA),
      .be_i     (AVL_BYTE_EN),
      .merged_o (enc_merged[i])
    );

    // Encrypted message word is writable except while the core is running.
    always_ff @(posedge CLK) begin
      if (RESET) enc_q[i] <= '0;
      else if (wr_en && state_q != ST_RUN && AVL_ADDR == ADDR_W'(ENC_BASE + i))
        enc_q[i] <= enc_merged[i];
    end

    assign AES_MSG_ENC[(MSG_WORDS-i)*DATA_W-1 -: DATA_W] = enc_q[i];
  end

  // Control FSM: start request, cycle counter, result capture; an abort beats a same-cycle done.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      cycles_q <= '0;
      for (int i = 0; i < MSG_WORDS; i++) dec_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_wr && start_bit) begin
            state_q  <= ST_RUN;
            start_q  <= 1'b1;
            cycles_q <= '0;
          end
        end
        ST_RUN: begin
          if (cycles_q != '1) cycles_q <= cycles_q + DATA_W'(1);
          if (start_wr && !start_bit) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
          end else if (AES_DONE) begin
            state_q <= ST_DONE;
            start_q <= 1'b0;
            for (int i = 0; i < MSG_WORDS; i++)
              dec_q[i] <= AES_MSG_DEC[(MSG_WORDS-i)*DATA_W-1 -: DATA_W];
          end
        end
        ST_DONE: begin
          if (start_wr && !start_bit) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  // Read mux over the current register contents, so a same-cycle write is not visible.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < KEY_WORDS; i++)
      if (AVL_ADDR == ADDR_W'(KEY_BASE + i)) readdata_d = key_q[i];
    for (int i = 0; i < MSG_WORDS; i++) begin
      if (AVL_ADDR == ADDR_W'(ENC_BASE + i)) readdata_d = enc_q[i];
      if (AVL_ADDR == ADDR_W'(DEC_BASE + i)) readdata_d = dec_q[i];
    end
    if (AVL_ADDR == ADDR_W'(CYC_ADDR))  readdata_d = cycles_q;
    if (AVL_ADDR == ADDR_W'(STA_ADDR))  readdata_d = {{(DATA_W-1){1'b0}}, state_q != ST_IDLE};
    if (AVL_ADDR == ADDR_W'(DONE_ADDR)) readdata_d = {{(DATA_W-1){1'b0}}, state_q == ST_DONE};
  end

  // Read data register holds its value between reads.
  always_ff @(posedge CLK) begin
    if (RESET) readdata_q <= '0;
    else if (rd_en) readdata_q <= readdata_d;
  end

  assign AVL_READDATA = readdata_q;
  assign AES_START    = start_q;
  assign EXPORT_DATA  = {key_q[0][DATA_W-1 -: DATA_W/2], key_q[KEY_WORDS-1][DATA_W/2-1:0]};

endmodule

// File: tb/tb_avalon_aes_regfile.sv
// tb/tb_avalon_aes_regfile.sv - self-checking bench for avalon_aes_regfile
module tb_avalon_aes_regfile;

  localparam int K = 4;
  localparam int M = 4;
  localparam int NADDR = 16;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]   AVL_BYTE_EN;
  logic [3:0]   AVL_ADDR;
  logic [31:0]  AVL_WRITEDATA, AVL_READDATA;
  logic         AES_START, AES_DONE;
  logic [127:0] AES_MSG_DEC, AES_KEY, AES_MSG_ENC;
  logic [31:0]  EXPORT_DATA;

  avalon_aes_regfile #(.DATA_W(32), .KEY_WORDS(K), .MSG_WORDS(M), .ADDR_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AES_START(AES_START), .AES_DONE(AES_DONE),
    .AES_MSG_DEC(AES_MSG_DEC), .AES_KEY(AES_KEY), .AES_MSG_ENC(AES_MSG_ENC),
    .EXPORT_DATA(EXPORT_DATA)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain arrays and two flags for "core running" / "result ready".
  logic [31:0] mk [K];
  logic [31:0] me [M];
  logic [31:0] md [M];
  logic [31:0] m_cyc, m_rd;
  bit          m_run, m_done;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a < K) return mk[a];
    if (a < K + M) return me[a-K];
    if (a < K + 2*M) return md[a-K-M];
    if (a == NADDR - 3) return m_cyc;
    if (a == NADDR - 2) return {31'd0, m_run | m_done};
    if (a == NADDR - 1) return {31'd0, m_done};
    return 32'd0;
  endfunction

  task automatic cyc(input bit rst, input bit cs, input bit rd, input bit wr, input int addr,
                     input logic [31:0] wd, input logic [3:0] be, input bit dn, input logic [127:0] dec);
    bit pre_run, pre_done, wr_a, rd_a, sw, sbit;
    RESET = rst; AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr; AVL_ADDR = addr[3:0];
    AVL_WRITEDATA = wd; AVL_BYTE_EN = be; AES_DONE = dn; AES_MSG_DEC = dec;
    @(posedge CLK);
    #1;
    pre_run = m_run; pre_done = m_done; wr_a = cs & wr; rd_a = cs & rd;
    if (rst) begin
      for (int i = 0; i < K; i++) mk[i] = '0;
      for (int i = 0; i < M; i++) begin me[i] = '0; md[i] = '0; end
      m_cyc = '0; m_rd = '0; m_run = 0; m_done = 0;
    end else begin
      if (rd_a) m_rd = m_read(addr);
      if (wr_a && !pre_run && addr < K) mk[addr] = merge(mk[addr], wd, be);
      if (wr_a && !pre_run && addr >= K && addr < K + M) me[addr-K] = merge(me[addr-K], wd, be);
      sw = wr_a && addr == NADDR - 2;
      sbit = be[0] ? wd[0] : (pre_run | pre_done);
      if (pre_run) begin
        if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (sw && !sbit) m_run = 0;
        else if (dn) begin
          m_run = 0; m_done = 1;
          for (int i = 0; i < M; i++) md[i] = dec[127-32*i -: 32];
        end
      end else if (pre_done) begin
        if (sw && !sbit) m_done = 0;
      end else if (sw && sbit) begin
        m_run = 1; m_cyc = '0;
      end
    end
    check("readdata", AVL_READDATA, m_rd);
    check("aes_start", AES_START, m_run);
    check("aes_key", AES_KEY, {mk[0], mk[1], mk[2], mk[3]});
    check("aes_msg_enc", AES_MSG_ENC, {me[0], me[1], me[2], me[3]});
    check("export_data", EXPORT_DATA, {mk[0][31:16], mk[K-1][15:0]});
    @(negedge CLK);
  endtask

  task automatic wr_reg(input int a, input logic [31:0] d);
    cyc(0, 1, 0, 1, a, d, 4'hF, 0, '0);
  endtask

  task automatic rd_reg(input int a);
    cyc(0, 1, 1, 0, a, '0, 4'h0, 0, '0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, '0, 4'h0, 0, '0);
  endtask

  initial begin
    RESET = 1; AVL_READ = 0; AVL_WRITE = 0; AVL_CS = 0; AVL_BYTE_EN = 0; AVL_ADDR = 0;
    AVL_WRITEDATA = 0; AES_DONE = 0; AES_MSG_DEC = 0;
    cyc(1, 0, 0, 0, 0, '0, 4'h0, 0, '0);
    cyc(1, 0, 0, 0, 0, '0, 4'h0, 0, '0);
    check("reset_readdata", AVL_READDATA, 32'h0);
    check("reset_start", AES_START, 1'b0);

    // Partial byte-enable write to key word 0.
    cyc(0, 1, 0, 1, 0, 32'hDEADBEEF, 4'b0011, 0, '0);
    rd_reg(0);
    check("be_write_read", AVL_READDATA, 32'h0000BEEF);

    // Full key, random encrypted message, then start.
    wr_reg(0, 32'h00112233); wr_reg(1, 32'h44556677); wr_reg(2, 32'h8899AABB); wr_reg(3, 32'hCCDDEEFF);
    for (int i = 0; i < M; i++) wr_reg(K + i, $urandom);
    wr_reg(NADDR - 2, 32'h1);
    check("start_level", AES_START, 1'b1);

    // Ten RUN cycles, the tenth carrying the done pulse; key writes in RUN are dropped.
    wr_reg(0, 32'hFFFFFFFF);
    rd_reg(0);
    check("run_key_locked", AVL_READDATA, 32'h00112233);
    rd_reg(NADDR - 3);
    for (int i = 0; i < 6; i++) idle();
    cyc(0, 0, 0, 0, 0, '0, 4'h0, 1, {4{32'hA5A5A5A5}});
    check("run_key_port", AES_KEY, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    rd_reg(NADDR - 1);
    check("done_read", AVL_READDATA, 32'h1);
    for (int a = 8; a < 12; a++) begin
      rd_reg(a);
      check("dec_read", AVL_READDATA, 32'hA5A5A5A5);
    end
    rd_reg(NADDR - 3);
    check("cycles_read", AVL_READDATA, 32'd10);

    // Back to idle, restart, and abort in the same cycle as a done pulse.
    wr_reg(NADDR - 2, 32'h0);
    wr_reg(NADDR - 2, 32'h1);
    idle(); idle(); idle();
    cyc(0, 1, 0, 1, NADDR - 2, 32'h0, 4'hF, 1, {4{32'h12345678}});
    check("abort_start", AES_START, 1'b0);
    rd_reg(NADDR - 1);
    check("abort_done", AVL_READDATA, 32'h0);
    rd_reg(NADDR - 2);
    check("abort_state", AVL_READDATA, 32'h0);
    rd_reg(8);
    check("abort_dec_kept", AVL_READDATA, 32'hA5A5A5A5);

    // Read-before-write on START and unmapped / read-only addresses.
    cyc(0, 1, 1, 1, NADDR - 2, 32'h1, 4'hF, 0, '0);
    check("rbw_start_old", AVL_READDATA, 32'h0);
    wr_reg(12, 32'hFFFFFFFF);
    rd_reg(12);
    check("unmapped_read", AVL_READDATA, 32'h0);
    wr_reg(8, 32'h0); wr_reg(NADDR - 1, 32'h1); wr_reg(NADDR - 3, 32'h0);
    rd_reg(8);
    check("dec_readonly", AVL_READDATA, 32'hA5A5A5A5);
    wr_reg(NADDR - 2, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int a;
      logic [31:0] d;
      a = $urandom_range(0, NADDR - 1);
      d = $urandom;
      if ($urandom_range(0, 3) == 0) a = NADDR - 2;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, a, d, 4'($urandom), $urandom_range(0, 5) == 0,
          {$urandom, $urandom, $urandom, $urandom});
    end

    // Reset in the middle of RUN, colliding with a write and a done pulse.
    cyc(1, 0, 0, 0, 0, '0, 4'h0, 0, '0);
    wr_reg(0, 32'h13572468);
    wr_reg(NADDR - 2, 32'h1);
    idle(); idle();
    check("pre_reset_start", AES_START, 1'b1);
    cyc(1, 1, 1, 1, 0, 32'hFFFFFFFF, 4'hF, 1, '1);
    check("mid_run_reset_start", AES_START, 1'b0);
    for (int a = 0; a < NADDR; a++) begin
      rd_reg(a);
      check("post_reset_read", AVL_READDATA, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
